// File: rtl/collision_scanner_if.sv
// Handshake and result bundle between the object-position registers,
// the collision scanner and the game-logic FSM.
interface collision_scanner_if #(
    parameter int N_ENEMIES = 4,
    parameter int COORD_W   = 10,
    parameter int IDX_W     = 2
);
    logic                             start;
    logic [2*COORD_W-1:0]             position;
    logic [N_ENEMIES*2*COORD_W-1:0]   e_positions;
    logic [N_ENEMIES-1:0]             e_valid;
    logic                             busy;
    logic                             done;
    logic [N_ENEMIES-1:0]             hit_mask;
    logic                             hit_any;
    logic [IDX_W-1:0]                 hit_index;
    logic [2:0]                       enemyCollide;

    modport master (
        output start, position, e_positions, e_valid,
        input  busy, done, hit_mask, hit_any, hit_index, enemyCollide
    );

    modport slave (
        input  start, position, e_positions, e_valid,
        output busy, done, hit_mask, hit_any, hit_index, enemyCollide
    );
endinterface

// File: rtl/collision_scanner.sv
// Player-vs-enemies box collision scanner, one enemy slot per clock.
// Snapshots inputs on start, reports a registered result set with done.
module collision_scanner #(
    parameter int N_ENEMIES = 4,
    parameter int COORD_W   = 10,
    parameter int HIT_W     = 16,
    parameter int HIT_H     = 19,
    parameter int IDX_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    collision_scanner_if.slave   bus
);
    localparam int CW2 = 2 * COORD_W;
    localparam int DW  = COORD_W + 1;
    localparam logic [DW-1:0]    LIM_X = DW'(HIT_W);
    localparam logic [DW-1:0]    LIM_Y = DW'(HIT_H);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_ENEMIES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t                     state_q;
    logic [IDX_W-1:0]           cnt_q;
    logic [CW2-1:0]             pos_q;
    logic [N_ENEMIES*CW2-1:0]   epos_q;
    logic [N_ENEMIES-1:0]       eval_q;
    logic [N_ENEMIES-1:0]       wmask_q;
    logic [IDX_W-1:0]           widx_q;
    logic [2:0]                 wdir_q;
    logic                       busy_q;
    logic                       done_q;
    logic [N_ENEMIES-1:0]       mask_q;
    logic                       any_q;
    logic [IDX_W-1:0]           idx_q;
    logic [2:0]                 dir_q;

    logic [CW2-1:0]             sel_e;
    logic signed [DW-1:0]       dx;
    logic signed [DW-1:0]       dy;
    logic [DW-1:0]              adx;
    logic [DW-1:0]              ady;
    logic [DW-1:0]              ph;
    logic [DW-1:0]              pv;
    logic                       hit_d;
    logic [2:0]                 dir_d;

    // Distance and direction for the snapshot enemy selected by cnt_q
    always_comb begin
        sel_e = epos_q[int'(cnt_q)*CW2 +: CW2];
        dx = $signed({1'b0, sel_e[CW2-1:COORD_W]})
           - $signed({1'b0, pos_q[CW2-1:COORD_W]});
        dy = $signed({1'b0, sel_e[COORD_W-1:0]})
           - $signed({1'b0, pos_q[COORD_W-1:0]});
        adx = dx[DW-1] ? -dx : dx;
        ady = dy[DW-1] ? -dy : dy;
        ph = LIM_X - adx;
        pv = LIM_Y - ady;
        hit_d = eval_q[cnt_q] && (adx <= LIM_X) && (ady <= LIM_Y);
        dir_d = 3'd0;
        // A dead-centre overlap always reports down
        if (dx == '0 && dy == '0) begin
            dir_d = 3'd2;
        end else if (pv <= ph) begin
            dir_d = dy[DW-1] ? 3'd1 : 3'd2;
        end else begin
            dir_d = dx[DW-1] ? 3'd3 : 3'd4;
        end
    end

    // Scan FSM: snapshot, walk the slots, publish results with a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
            epos_q  <= '0;
            eval_q  <= '0;
            wmask_q <= '0;
            widx_q  <= '0;
            wdir_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mask_q  <= '0;
            any_q   <= 1'b0;
            idx_q   <= '0;
            dir_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        pos_q   <= bus.position;
                        epos_q  <= bus.e_positions;
                        eval_q  <= bus.e_valid;
                        wmask_q <= '0;
                        widx_q  <= '0;
                        wdir_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (hit_d) begin
                        wmask_q[cnt_q] <= 1'b1;
                        // Only the first hit of the scan owns index/direction
                        if (wmask_q == '0) begin
                            widx_q <= cnt_q;
                            wdir_q <= dir_d;
                        end
                    end
                    if (cnt_q == LAST) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    mask_q  <= wmask_q;
                    any_q   <= |wmask_q;
                    idx_q   <= widx_q;
                    dir_q   <= wdir_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.hit_mask     = mask_q;
    assign bus.hit_any      = any_q;
    assign bus.hit_index    = idx_q;
    assign bus.enemyCollide = dir_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Bench for collision_scanner: vector table with scoreboard queue,
// plus hand-written mid-scan start, input-change and reset sequences.
module tb_collision_scanner;
    localparam int N  = 4;
    localparam int CW = 10;
    localparam int IW = 2;

    typedef struct packed {
        logic [2*CW-1:0]   pos;
        logic [N*2*CW-1:0] epos;
        logic [N-1:0]      valid;
        logic [N-1:0]      mask;
        logic [IW-1:0]     idx;
        logic [2:0]        dir;
    } vec_t;

    typedef struct packed {
        logic [N-1:0]  mask;
        logic [IW-1:0] idx;
        logic [2:0]    dir;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[9];

    always #5 clk = ~clk;

    collision_scanner_if #(.N_ENEMIES(N), .COORD_W(CW), .IDX_W(IW)) bus ();

    collision_scanner #(
        .N_ENEMIES(N),
        .COORD_W(CW),
        .HIT_W(16),
        .HIT_H(19),
        .IDX_W(IW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    function automatic logic [2*CW-1:0] pk(int x, int y);
        return {CW'(x), CW'(y)};
    endfunction

    function automatic logic [N*2*CW-1:0] ep4(int x0, int y0, int x1, int y1,
                                              int x2, int y2, int x3, int y3);
        return {pk(x3, y3), pk(x2, y2), pk(x1, y1), pk(x0, y0)};
    endfunction

    function automatic vec_t mkv(logic [2*CW-1:0] p, logic [N*2*CW-1:0] e,
                                 logic [N-1:0] v, logic [N-1:0] m,
                                 int i, int d);
        vec_t r;
        r.pos = p;
        r.epos = e;
        r.valid = v;
        r.mask = m;
        r.idx = IW'(i);
        r.dir = 3'(d);
        return r;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic drive_start(vec_t v);
        exp_t e;
        @(negedge clk);
        bus.position = v.pos;
        bus.e_positions = v.epos;
        bus.e_valid = v.valid;
        bus.start = 1'b1;
        e.mask = v.mask;
        e.idx = v.idx;
        e.dir = v.dir;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic cmp_out(string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_mask"}, int'(bus.hit_mask), int'(e.mask));
            chk({tag, "_any"}, int'(bus.hit_any), int'(|e.mask));
            chk({tag, "_idx"}, int'(bus.hit_index), int'(e.idx));
            chk({tag, "_dir"}, int'(bus.enemyCollide), int'(e.dir));
        end
    endtask

    task automatic collect(string tag);
        int k = 0;
        bit seen = 1'b0;
        while (!seen && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) chk({tag, "_busy"}, int'(bus.busy), 1);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            chk({tag, "_done_timeout"}, 0, 1);
            void'(sb.pop_front());
        end else begin
            chk({tag, "_latency"}, k, N + 1);
            cmp_out(tag);
            chk({tag, "_busy_at_done"}, int'(bus.busy), 0);
            @(posedge clk);
            #1;
            chk({tag, "_done_width"}, int'(bus.done), 0);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_mask"}, int'(bus.hit_mask), 0);
        chk({tag, "_any"}, int'(bus.hit_any), 0);
        chk({tag, "_idx"}, int'(bus.hit_index), 0);
        chk({tag, "_dir"}, int'(bus.enemyCollide), 0);
    endtask

    initial begin
        int nd;
        int lat;

        vecs[0] = mkv(pk(100, 100), ep4(500, 500, 500, 500, 105, 110, 500, 500),
                      4'hF, 4'b0100, 2, 2);
        vecs[1] = mkv(pk(100, 100), ep4(500, 500, 500, 500, 105, 90, 500, 500),
                      4'hF, 4'b0100, 2, 1);
        vecs[2] = mkv(pk(5, 200), ep4(0, 202, 500, 500, 500, 500, 500, 500),
                      4'hF, 4'b0001, 0, 3);
        vecs[3] = mkv(pk(1000, 50), ep4(1016, 50, 500, 500, 500, 500, 500, 500),
                      4'hF, 4'b0001, 0, 4);
        vecs[4] = mkv(pk(1000, 50), ep4(1017, 50, 500, 500, 500, 500, 500, 500),
                      4'hF, 4'b0000, 0, 0);
        vecs[5] = mkv(pk(300, 300), ep4(300, 300, 310, 300, 500, 500, 300, 305),
                      4'b1110, 4'b1010, 1, 4);
        vecs[6] = mkv(pk(200, 200), ep4(500, 500, 200, 219, 200, 180, 500, 500),
                      4'hF, 4'b0010, 1, 2);
        vecs[7] = mkv(pk(0, 0), ep4(1020, 0, 500, 500, 500, 500, 0, 0),
                      4'hF, 4'b1000, 3, 2);
        vecs[8] = mkv(pk(1023, 1023), ep4(1007, 1004, 1006, 1023, 5, 1023, 500, 500),
                      4'hF, 4'b0001, 0, 1);

        bus.start = 1'b0;
        bus.position = '0;
        bus.e_positions = '0;
        bus.e_valid = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_zero("reset");
        nd = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done) nd++;
        end
        chk("idle_done_count", nd, 0);
        chk("idle_busy", int'(bus.busy), 0);

        for (int i = 0; i < 9; i++) begin
            drive_start(vecs[i]);
            collect($sformatf("vec%0d", i));
        end

        drive_start(vecs[1]);
        bus.e_positions = ep4(500, 500, 500, 500, 500, 500, 500, 500);
        nd = 0;
        lat = 0;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) bus.start = 1'b1;
            if (i == 2) bus.start = 1'b0;
            if (bus.done) begin
                nd++;
                lat = i;
                cmp_out("midscan");
            end
        end
        chk("midscan_done_count", nd, 1);
        chk("midscan_latency", lat, N + 1);
        chk("midscan_sb_left", sb.size(), 0);

        drive_start(vecs[0]);
        collect("prereset");
        drive_start(vecs[0]);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk_zero("rst_mid");
        nd = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.done) nd++;
        end
        chk("rst_mid_done_count", nd, 0);
        chk_zero("rst_mid_after");

        drive_start(vecs[5]);
        collect("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/collision_scanner.md
Name: collision_scanner

Overview:
- Parametrised successor to the single-pair player/enemy collision check.
- Compares one player box against up to N_ENEMIES enemy boxes, time-multiplexed at one enemy per clock.
- Uses sign-correct distance arithmetic and tracks which enemies were hit.
- Sits between the object-position registers and the game-logic FSM. Triggered once per frame by a start strobe; delivers a registered result set with a done pulse.

Parameters:
- N_ENEMIES, 4, number of enemy slots scanned (1..16).
- COORD_W, 10, bits per coordinate. Positions are packed {x, y}, x in the upper half.
- HIT_W, 16, horizontal overlap threshold in pixels (max |dx| counted as a hit).
- HIT_H, 19, vertical overlap threshold in pixels (max |dy| counted as a hit).
- IDX_W, 2, width of the enemy index. Must be >= clog2(N_ENEMIES); parent sets it.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle scan request.
- position, input, 2*COORD_W, player {x, y}.
- e_positions, input, N_ENEMIES*2*COORD_W, enemy k occupies bits [(k+1)*2*COORD_W-1 : k*2*COORD_W].
- e_valid, input, N_ENEMIES, per-slot enable. An invalid slot never hits.
- busy, output, 1, high while scanning.
- done, output, 1, one-cycle pulse when results update.
- hit_mask, output, N_ENEMIES, bit k set if enemy k collided.
- hit_any, output, 1, OR of hit_mask.
- hit_index, output, IDX_W, lowest-index colliding enemy; 0 if none.
- enemyCollide, output, 3, direction of the hit_index enemy: 0 none, 1 up, 2 down, 3 left, 4 right.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, hit_mask=0, hit_any=0, hit_index=0, enemyCollide=0; internal counter and working mask cleared.
- FSM states:
  - IDLE: on start=1, snapshot position, e_positions and e_valid into internal registers; clear working mask and first-hit registers; cnt=0; go to SCAN; busy=1 from the next cycle.
  - SCAN: each cycle, evaluate snapshot enemy cnt, then cnt++. When cnt==N_ENEMIES-1 has been evaluated, go to DONE.
  - DONE: copy working results to the outputs; done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: start at edge T → done high in cycle T+N_ENEMIES+1. Outputs are valid from that cycle and held until the next done.
- Start while busy or in DONE is ignored and not queued. Input changes during a scan have no effect; only the snapshot is used.
- Per-enemy test, for enemy k:
  - dx = ex - px and dy = ey - py, each computed as a (COORD_W+1)-bit signed value from zero-extended operands. No unsigned wrap.
  - Hit if e_valid[k] & |dx| <= HIT_W & |dy| <= HIT_H.
- Direction on hit:
  - Compare pv = HIT_H - |dy| against ph = HIT_W - |dx|.
  - If pv <= ph, vertical: dy >= 0 → 2 (down), else 1 (up).
  - Otherwise horizontal: dx >= 0 → 4 (right), else 3 (left).
  - Tie resolves to vertical. dx=dy=0 gives 2.
- First-hit capture: hit_index and direction are latched only on the first hit of a scan. Later hits set only their mask bit.
- Boundaries:
  - |dx|==HIT_W exactly is a hit; HIT_W+1 is not. Same rule on the y axis with HIT_H.
  - Coordinates at 0 and at 2^COORD_W-1 produce correct magnitudes with no wrap.
- Reset mid-scan aborts the scan: no done pulse, all outputs zero.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release → all outputs 0, busy=0, no done pulse over 20 cycles.
- Single vertical hit, N=4: player (100,100), enemy2 (105,110), others (500,500), all valid; start → done 5 cycles later, hit_mask=4'b0100, hit_index=2, enemyCollide=2. Enemy2 moved to (105,90) → enemyCollide=1.
- Horizontal and wrap-safe: player (5,200), enemy0 (0,202) → hit, dx=-5, enemyCollide=3 (left). Player (1000,50), enemy0 (1016,50) → hit, right (4). Enemy0 at (1017,50) → no hit, enemyCollide=0.
- Multi-hit priority: enemies 1 and 3 overlap, enemy0 invalid but overlapping → hit_mask=4'b1010, hit_index=1, hit_any=1, direction taken from enemy1.
- Start during scan and input change mid-scan: second start at cycle T+2 ignored; e_positions altered at T+1 → results match the T snapshot; exactly one done pulse.
- Reset mid-scan: assert rst_n=0 at T+2 → no done pulse, outputs 0; a fresh start afterwards completes normally.
